// File: rtl/slot_count_gen.sv
// -----------------------------------------------------------------------------
// slot_count_gen
//   Frame position generator for the downstream slot-address decoder. Walks
//   `count` through 0..FRAME_LEN-1 (FRAME_LEN = SLOT_LEN*NUM_SLOTS), one step
//   every PRESCALE clocks, with start/stop/pause control and single-shot or
//   continuous framing.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level; begins a frame when idle (ignored while running)
//   stop       in   aborts the frame and returns to idle (beats everything)
//   pause      in   freezes count and prescaler while running
//   cont       in   1 = continuous frames, 0 = single frame; sampled at wrap
//   count      out  [7:0] frame position 0..FRAME_LEN-1
//   busy       out  high while running
//   frame_done out  one-cycle pulse on the wrap step
//   slot_edge  out  one-cycle pulse when count steps onto a slot boundary
//   frame_cnt  out  [7:0] completed frames since reset, modulo 256
// -----------------------------------------------------------------------------
module slot_count_gen #(
  parameter int SLOT_LEN  = 13,
  parameter int NUM_SLOTS = 16,
  parameter int PRESCALE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       cont,
  output logic [7:0] count,
  output logic       busy,
  output logic       frame_done,
  output logic       slot_edge,
  output logic [7:0] frame_cnt
);

  localparam int FRAME_LEN = SLOT_LEN * NUM_SLOTS;

  localparam logic [7:0] LAST_CNT  = 8'(FRAME_LEN - 1);
  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);
  localparam logic [7:0] SLOT_MAX  = 8'(SLOT_LEN - 1);

  if (FRAME_LEN > 256 || FRAME_LEN < 2) begin : g_bad_frame
    $error("slot_count_gen: FRAME_LEN must be in 2..256");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_presc
    $error("slot_count_gen: PRESCALE must be in 1..256");
  end

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] presc_q, presc_d;
  // Position inside the current slot; avoids a modulo on count.
  logic [7:0] slot_pos_q, slot_pos_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       frame_done_q, frame_done_d;
  logic       slot_edge_q, slot_edge_d;

  logic step_due;
  logic wrap;

  assign step_due = (presc_q == PRESC_MAX);
  // Stop and pause both suppress the step, so a stop on the wrap cycle never
  // produces frame_done or a frame_cnt increment.
  assign wrap = (state_q == S_RUN) && !stop && !pause && step_due &&
                (count_q == LAST_CNT);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= 8'd0;
      presc_q      <= 8'd0;
      slot_pos_q   <= 8'd0;
      frame_cnt_q  <= 8'd0;
      frame_done_q <= 1'b0;
      slot_edge_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      slot_pos_q   <= slot_pos_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      slot_edge_q  <= slot_edge_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && !stop) state_d = S_RUN;
      S_RUN: begin
        if (stop)             state_d = S_IDLE;
        else if (wrap && !cont) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter / pulse logic
  always_comb begin
    count_d      = count_q;
    presc_d      = presc_q;
    slot_pos_d   = slot_pos_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    slot_edge_d  = 1'b0;

    if (state_q != S_RUN || stop) begin
      // Idle, or leaving run on stop: everything parks at zero.
      count_d    = 8'd0;
      presc_d    = 8'd0;
      slot_pos_d = 8'd0;
    end else if (!pause) begin
      if (step_due) begin
        presc_d = 8'd0;
        if (count_q == LAST_CNT) begin
          count_d      = 8'd0;
          slot_pos_d   = 8'd0;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          // Wrapping onto 0 is a slot edge only if the frame continues.
          slot_edge_d  = cont;
        end else begin
          count_d = count_q + 8'd1;
          if (slot_pos_q == SLOT_MAX) begin
            slot_pos_d  = 8'd0;
            slot_edge_d = 1'b1;
          end else begin
            slot_pos_d = slot_pos_q + 8'd1;
          end
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  // Outputs
  assign count      = count_q;
  assign busy       = (state_q == S_RUN);
  assign frame_done = frame_done_q;
  assign slot_edge  = slot_edge_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_slot_count_gen.sv
// -----------------------------------------------------------------------------
// tb_slot_count_gen
//   Two instances (PRESCALE=1 and PRESCALE=4) share one set of control inputs.
//   A behavioural frame model predicts both every cycle; directed scenarios add
//   hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_slot_count_gen;

  localparam int SLOT_LEN  = 13;
  localparam int NUM_SLOTS = 16;
  localparam int FRAME_LEN = SLOT_LEN * NUM_SLOTS;

  logic clk = 1'b0;
  logic rst_n, start, stop, pause, cont;

  logic [7:0] count1, count4, fcnt1, fcnt4;
  logic       busy1, busy4, fd1, fd4, se1, se4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slot_count_gen #(.SLOT_LEN(SLOT_LEN), .NUM_SLOTS(NUM_SLOTS), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .cont(cont),
    .count(count1), .busy(busy1), .frame_done(fd1), .slot_edge(se1), .frame_cnt(fcnt1)
  );

  slot_count_gen #(.SLOT_LEN(SLOT_LEN), .NUM_SLOTS(NUM_SLOTS), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .cont(cont),
    .count(count4), .busy(busy4), .frame_done(fd4), .slot_edge(se4), .frame_cnt(fcnt4)
  );

  // ---------------- behavioural model (index 0: PRESCALE=1, 1: PRESCALE=4)
  bit m_run [2];
  int m_cnt [2];
  int m_pre [2];
  int m_fc  [2];
  bit m_fd  [2];
  bit m_se  [2];

  function automatic int psc(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] <= 1'b0; m_cnt[i] <= 0; m_pre[i] <= 0;
        m_fc[i]  <= 0;    m_fd[i]  <= 1'b0; m_se[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int c, p, f;
        bit r, d, s;
        c = m_cnt[i]; p = m_pre[i]; f = m_fc[i]; r = m_run[i]; d = 1'b0; s = 1'b0;
        if (!r) begin
          if (start && !stop) r = 1'b1;
        end else if (stop) begin
          r = 1'b0; c = 0; p = 0;
        end else if (!pause) begin
          if (p == psc(i) - 1) begin
            p = 0;
            if (c == FRAME_LEN - 1) begin
              c = 0; d = 1'b1; f = (f + 1) % 256; s = cont;
              if (!cont) r = 1'b0;
            end else begin
              c = c + 1;
              s = ((c % SLOT_LEN) == 0);
            end
          end else begin
            p = p + 1;
          end
        end
        m_cnt[i] <= c; m_pre[i] <= p; m_fc[i] <= f; m_run[i] <= r;
        m_fd[i]  <= d; m_se[i]  <= s;
      end
    end
  end

  // ---------------- checking helpers
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model;
    chk("model count p1",  int'(count1), m_cnt[0]);
    chk("model busy p1",   int'(busy1),  int'(m_run[0]));
    chk("model fdone p1",  int'(fd1),    int'(m_fd[0]));
    chk("model sedge p1",  int'(se1),    int'(m_se[0]));
    chk("model fcnt p1",   int'(fcnt1),  m_fc[0]);
    chk("model count p4",  int'(count4), m_cnt[1]);
    chk("model busy p4",   int'(busy4),  int'(m_run[1]));
    chk("model fdone p4",  int'(fd4),    int'(m_fd[1]));
    chk("model sedge p4",  int'(se4),    int'(m_se[1]));
    chk("model fcnt p4",   int'(fcnt4),  m_fc[1]);
    chk("count range p1",  int'(count1 <= 8'(FRAME_LEN - 1)), 1);
    chk("count range p4",  int'(count4 <= 8'(FRAME_LEN - 1)), 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; cont = 1'b0;
    fork
      begin : compare_proc
        forever begin
          @(negedge clk);
          compare_model();
        end
      end
      begin : stimulus
        int n, se_cnt, fd_cnt, fc_before;

        // ---- reset state
        tick; tick;
        chk("reset count",  int'(count1), 0);
        chk("reset busy",   int'(busy1),  0);
        chk("reset fcnt",   int'(fcnt1),  0);
        chk("reset pulses", int'(fd1 | se1 | fd4 | se4), 0);
        rst_n = 1'b1;
        tick;
        chk("post-reset pulses", int'(fd1 | se1), 0);

        // ---- single frame at PRESCALE=1
        cont = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("t1 busy on entry", int'(busy1), 1);
        chk("t1 count on entry", int'(count1), 0);
        se_cnt = 0; fd_cnt = 0;
        for (int k = 1; k < FRAME_LEN; k++) begin
          tick;
          chk("t1 count seq", int'(count1), k);
          if (se1) begin
            se_cnt++;
            chk("t1 slot_edge pos", int'(count1) % SLOT_LEN, 0);
          end
          if (fd1) fd_cnt++;
        end
        chk("t1 no early fdone", fd_cnt, 0);
        tick;
        chk("t1 wrap fdone", int'(fd1), 1);
        chk("t1 wrap count", int'(count1), 0);
        chk("t1 wrap busy", int'(busy1), 0);
        chk("t1 wrap fcnt", int'(fcnt1), 1);
        chk("t1 wrap sedge", int'(se1), 0);
        chk("t1 slot_edge total", se_cnt, 15);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("t1 p4 stopped", int'(busy4), 0);
        chk("t1 p4 fcnt", int'(fcnt4), 0);

        // ---- continuous frames at PRESCALE=4
        cont = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        se_cnt = 0; fd_cnt = 0;
        for (int t = 1; t <= 2 * 4 * FRAME_LEN; t++) begin
          tick;
          if (count4 != 8'((t / 4) % FRAME_LEN))
            chk("t2 p4 count hold", int'(count4), (t / 4) % FRAME_LEN);
          if (se4) se_cnt++;
          if (fd4) begin
            fd_cnt++;
            chk("t2 p4 fdone cycle", t, fd_cnt * 4 * FRAME_LEN);
            chk("t2 p4 wrap sedge", int'(se4), 1);
          end
        end
        chk("t2 p4 fdone total", fd_cnt, 2);
        chk("t2 p4 fcnt", int'(fcnt4), 2);
        chk("t2 p4 sedge total", se_cnt, 32);
        chk("t2 p4 busy", int'(busy4), 1);
        chk("t2 p1 fcnt", int'(fcnt1), 9);
        stop = 1'b1;
        tick;
        stop = 1'b0; cont = 1'b0;

        // ---- pause at count=50
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (count1 != 8'd50 && n < 300) begin tick; n++; end
        chk("t3 reached 50", int'(count1), 50);
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
          tick;
          chk("t3 paused count", int'(count1), 50);
          chk("t3 paused pulses", int'(se1 | fd1 | se4 | fd4), 0);
        end
        pause = 1'b0;
        tick;
        chk("t3 resume count", int'(count1), 51);

        // ---- stop on the wrap step
        n = 0;
        while (count1 != 8'd207 && n < 300) begin tick; n++; end
        chk("t4 reached 207", int'(count1), 207);
        fc_before = int'(fcnt1);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("t4 stop count", int'(count1), 0);
        chk("t4 stop busy", int'(busy1), 0);
        chk("t4 stop fdone", int'(fd1), 0);
        chk("t4 stop fcnt", int'(fcnt1), fc_before);

        // ---- asynchronous reset mid-frame
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (count1 != 8'd120 && n < 300) begin tick; n++; end
        chk("t5 reached 120", int'(count1), 120);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async count", int'(count1), 0);
        chk("t5 async busy", int'(busy1 | busy4), 0);
        chk("t5 async fcnt", int'(fcnt1 | fcnt4), 0);
        chk("t5 async pulses", int'(fd1 | se1 | fd4 | se4), 0);
        tick;
        rst_n = 1'b1;
        start = 1'b1; stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick;
          chk("t5 start+stop idle", int'(busy1), 0);
        end
        start = 1'b0; stop = 1'b0;

        // ---- 256 continuous frames, frame_cnt wraps
        cont = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        fd_cnt = 0; n = 0;
        while (fd_cnt < 256 && n < 256 * FRAME_LEN + 20) begin
          tick; n++;
          if (fd1) fd_cnt++;
        end
        chk("t6 frames seen", fd_cnt, 256);
        chk("t6 cycles", n, 256 * FRAME_LEN);
        chk("t6 fcnt wrap", int'(fcnt1), 0);
        chk("t6 busy", int'(busy1), 1);
        stop = 1'b1;
        tick;
        stop = 1'b0; cont = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

endmodule
